// File: rtl/des_pkg.sv
// DES constant tables, the generic table-driven permutation and the
// elaboration-time key schedule shared by the datapath helper block.
package des_pkg;

    typedef enum logic [2:0] {PT_IP, PT_E, PT_P, PT_PC1, PT_PC2} perm_e;

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    localparam int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                                16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                  41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    // Each S-box row-major: entry index = {row(b1,b6), column(b2..b5)}.
    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic int tbl_at(input perm_e sel, input int j);
        case (sel)
            PT_IP:   return IP_T[j-1];
            PT_E:    return E_T[j-1];
            PT_P:    return P_T[j-1];
            PT_PC1:  return PC1_T[j-1];
            PT_PC2:  return PC2_T[j-1];
            default: return 1;
        endcase
    endfunction

    // Operands are right-aligned in 64 bits; DES bit i of a W-bit value sits at index W-i.
    function automatic logic [63:0] permute(input logic [63:0] src, input int src_w,
                                            input int dst_w, input perm_e sel);
        logic [63:0] res;
        res = '0;
        for (int j = 1; j <= 64; j++) begin
            if (j <= dst_w) res[6'(dst_w - j)] = src[6'(src_w - tbl_at(sel, j))];
        end
        return res;
    endfunction

    // Returns K1..K16 packed with K(n+1) at bits [n*48 +: 48].
    function automatic logic [767:0] key_schedule(input logic [63:0] key);
        logic [63:0]  cd;
        logic [63:0]  k64;
        logic [27:0]  c;
        logic [27:0]  d;
        logic [767:0] ks;
        ks = '0;
        cd = permute(key, 64, 56, PT_PC1);
        c  = cd[55:28];
        d  = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFT_T[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            k64 = permute({8'h00, c, d}, 56, 48, PT_PC2);
            ks  = {k64[47:0], ks[767:48]};
        end
        return ks;
    endfunction

endpackage

// File: rtl/des_f.sv
// Combinational DES round function f(R, K): expansion, key mix, S-boxes, P.
module des_f
    import des_pkg::*;
(
    input  logic [32:1] r_i,
    input  logic [48:1] k_i,
    output logic [32:1] f_o
);

    logic [63:0] e_w;
    logic [47:0] x_w;
    logic [31:0] s_w;
    logic [63:0] p_w;
    logic [5:0]  six;

    always_comb begin
        e_w = permute({32'h0, r_i}, 32, 48, PT_E);
        x_w = e_w[47:0] ^ k_i;
        s_w = '0;
        six = '0;
        // S1 consumes the leftmost six bits and ends up in the top nibble.
        for (int i = 0; i < 8; i++) begin
            six = 6'(x_w >> (42 - 6 * i));
            s_w = {s_w[27:0], 4'(SBOX[3'(i)][{six[5], six[0], six[4:1]}])};
        end
        p_w = permute({32'h0, s_w}, 32, 32, PT_P);
        f_o = p_w[31:0];
    end

endmodule

// File: rtl/des_ip_ksel_f.sv
// Registered DES helper: initial permutation, fixed-key subkey select and
// round function, all presented one cycle after in_valid.
module des_ip_ksel_f
    import des_pkg::*;
#(
    parameter logic [63:0] KEY = 64'h133457799BBCDFF1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [64:1] msg,
    input  logic [5:1]  round_num,
    input  logic [32:1] r_in,
    output logic [64:1] ip_out,
    output logic [48:1] k_out,
    output logic [32:1] f_out,
    output logic        out_valid
);

    localparam logic [767:0] SUBKEYS = key_schedule(KEY);

    logic [63:0] ip_d;
    logic [47:0] k_d;
    logic [31:0] f_d;
    logic [63:0] ip_q;
    logic [47:0] k_q;
    logic [31:0] f_q;
    logic        vld_q;

    always_comb begin
        ip_d = permute(msg, 64, 64, PT_IP);
        k_d  = '0;
        // Rounds 16..31 have no subkey and deliberately select zero.
        if (!round_num[5]) begin
            for (int i = 0; i < 16; i++) begin
                if (round_num[4:1] == 4'(i)) k_d = SUBKEYS[i*48 +: 48];
            end
        end
    end

    des_f u_f (
        .r_i (r_in),
        .k_i (k_d),
        .f_o (f_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            ip_q  <= '0;
            k_q   <= '0;
            f_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                ip_q <= ip_d;
                k_q  <= k_d;
                f_q  <= f_d;
            end
        end
    end

    assign ip_out    = ip_q;
    assign k_out     = k_q;
    assign f_out     = f_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_des_ip_ksel_f.sv
// Directed self-checking bench for des_ip_ksel_f, including a full
// 16-round DES encryption driven through the block's f output.
module tb_des_ip_ksel_f;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [64:1] msg;
    logic [5:1]  round_num;
    logic [32:1] r_in;
    logic [64:1] ip_out;
    logic [48:1] k_out;
    logic [32:1] f_out;
    logic        out_valid;

    int n_chk  = 0;
    int n_fail = 0;

    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};

    des_ip_ksel_f dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .msg       (msg),
        .round_num (round_num),
        .r_in      (r_in),
        .ip_out    (ip_out),
        .k_out     (k_out),
        .f_out     (f_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [32:1] l_h, r_h, t_h;
    logic [64:1] pre, ct;

    initial begin
        rst = 1'b0; in_valid = 1'b0; msg = '0; round_num = '0; r_in = '0;
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        chk("rst_ip", 64'(ip_out), 64'h0);
        chk("rst_k", 64'(k_out), 64'h0);
        chk("rst_f", 64'(f_out), 64'h0);
        chk("rst_vld", 64'(out_valid), 64'h0);

        in_valid = 1'b1; msg = 64'h0123456789ABCDEF; round_num = 5'd0; r_in = 32'hF0AAF0AA;
        cyc();
        chk("ip", 64'(ip_out), 64'hCC00CCFFF0AAF0AA);
        chk("k1", 64'(k_out), 64'h1B02EFFC7072);
        chk("f1", 64'(f_out), 64'h234AA9BB);
        chk("vld", 64'(out_valid), 64'h1);
        chk("r1", 64'(32'hCC00CCFF ^ f_out), 64'hEF4A6544);

        round_num = 5'd15;
        cyc();
        chk("k16", 64'(k_out), 64'hCB3D8B0E17F5);
        round_num = 5'd16;
        cyc();
        chk("k_r16", 64'(k_out), 64'h0);

        in_valid = 1'b0; msg = '0; round_num = 5'd0; r_in = '0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_vld", 64'(out_valid), 64'h0);
            chk("hold_ip", 64'(ip_out), 64'hCC00CCFFF0AAF0AA);
            chk("hold_k", 64'(k_out), 64'h0);
        end

        // Feistel rounds run in the bench, using only the block's f output.
        l_h = 32'hCC00CCFF;
        r_h = 32'hF0AAF0AA;
        msg = 64'h0123456789ABCDEF;
        for (int n = 0; n < 16; n++) begin
            in_valid = 1'b1; round_num = 5'(n); r_in = r_h;
            cyc();
            t_h = l_h ^ f_out;
            l_h = r_h;
            r_h = t_h;
        end
        pre = {r_h, l_h};
        ct  = '0;
        for (int j = 1; j <= 64; j++) ct[65 - j] = pre[65 - FP_T[j-1]];
        chk("des_ct", 64'(ct), 64'h85E813540F0AB405);

        in_valid = 1'b1; rst = 1'b0; round_num = 5'd3; r_in = 32'h12345678;
        cyc();
        chk("mid_rst_ip", 64'(ip_out), 64'h0);
        chk("mid_rst_k", 64'(k_out), 64'h0);
        chk("mid_rst_f", 64'(f_out), 64'h0);
        chk("mid_rst_vld", 64'(out_valid), 64'h0);
        rst = 1'b1; in_valid = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
